// File: rtl/scan_sequencer_2to4.sv
// Scan sequencer for a 2-to-4 digit decoder: walks the unmasked digits with a blank gap
// and a dwell per digit, presents the latched nibble, and pulses frame_done on scan wrap.
module scan_sequencer_2to4 #(
  parameter int DWELL = 1000,
  parameter int BLANK = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic [3:0]  mask,
  input  logic [15:0] data,
  output logic [1:0]  sel,
  output logic        en,
  output logic [3:0]  digit,
  output logic        frame_done,
  output logic        busy
);

  localparam int MAXC = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int CW   = $clog2(MAXC) + 1;
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK - 1);
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BLANK = 2'd1,
    S_DRIVE = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [1:0]      sel_nxt;
  logic [3:0]      digit_nxt;
  logic            fd_nxt;
  logic [1:0]      next_idx;
  logic            wrap;

  function automatic logic [1:0] lowest_set(input logic [3:0] m);
    lowest_set = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (m[i]) lowest_set = 2'(i);
    end
  endfunction

  // Search strictly after cur, wrapping; k=4 lands back on cur for the single-digit case.
  function automatic logic [1:0] next_set(input logic [3:0] m, input logic [1:0] cur);
    logic [1:0] idx;
    logic       found;
    next_set = cur;
    found    = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = cur + 2'(k);
      if (!found && m[idx]) begin
        next_set = idx;
        found    = 1'b1;
      end
    end
  endfunction

  assign next_idx = next_set(mask, sel);
  assign wrap     = (next_idx <= sel);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    sel_nxt   = sel;
    digit_nxt = digit;
    fd_nxt    = 1'b0;
    case (state)
      S_IDLE: begin
        if (run && (mask != 4'd0)) begin
          sel_nxt   = lowest_set(mask);
          cnt_nxt   = '0;
          state_nxt = S_BLANK;
        end
      end
      S_BLANK: begin
        if (cnt == BLANK_LAST) begin
          cnt_nxt   = '0;
          digit_nxt = data[{sel, 2'b00} +: 4];
          state_nxt = S_DRIVE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_DRIVE: begin
        if (cnt == DWELL_LAST) begin
          cnt_nxt = '0;
          fd_nxt  = wrap && (mask != 4'd0);
          if (run && (mask != 4'd0)) begin
            sel_nxt   = next_idx;
            state_nxt = S_BLANK;
          end else begin
            state_nxt = S_IDLE;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // en/busy are registered copies of the next state so every output is a flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      sel        <= 2'd0;
      digit      <= 4'd0;
      en         <= 1'b0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      sel        <= sel_nxt;
      digit      <= digit_nxt;
      en         <= (state_nxt == S_DRIVE);
      frame_done <= fd_nxt;
      busy       <= (state_nxt != S_IDLE);
    end
  end

endmodule

// File: tb/tb_scan_sequencer_2to4.sv
// Bench for scan_sequencer_2to4: directed scan patterns and random run/mask/data/rst
// traffic compared every cycle against a phase-timeline model of the scan.
module tb_scan_sequencer_2to4;

  localparam int DWELL = 4;
  localparam int BLANK = 2;

  logic        clk;
  logic        rst;
  logic        run;
  logic [3:0]  mask;
  logic [15:0] data;
  logic [1:0]  sel;
  logic        en;
  logic [3:0]  digit;
  logic        frame_done;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Model: scanning flag, phase within the BLANK+DWELL period, selected digit.
  bit active;
  int ph;
  int m_sel;
  int m_digit;
  bit m_fd;

  int exp_period;
  int last_fd;
  int npulse;

  scan_sequencer_2to4 #(.DWELL(DWELL), .BLANK(BLANK)) dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .mask       (mask),
    .data       (data),
    .sel        (sel),
    .en         (en),
    .digit      (digit),
    .frame_done (frame_done),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d", tag, cyc, got, exp);
    end
  endtask

  task automatic model_step();
    int nxt;
    int s;
    if (rst) begin
      active = 0; ph = 0; m_sel = 0; m_digit = 0; m_fd = 0;
      return;
    end
    m_fd = 0;
    if (!active) begin
      if (run && mask != 0) begin
        for (int i = 3; i >= 0; i--) if (mask[i]) m_sel = i;
        active = 1;
        ph = 0;
      end
    end else if (ph == BLANK - 1) begin
      m_digit = (data >> (4 * m_sel)) & 16'hF;
      ph++;
    end else if (ph == BLANK + DWELL - 1) begin
      nxt = -1;
      for (int d = 1; d <= 4; d++) begin
        s = (m_sel + d) % 4;
        if (nxt < 0 && mask[s]) nxt = s;
      end
      if (mask != 0) m_fd = (nxt <= m_sel);
      if (run && mask != 0) begin
        m_sel = nxt;
        ph = 0;
      end else begin
        active = 0;
        ph = 0;
      end
    end else begin
      ph++;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    cyc++;
    check("sel", int'(sel), m_sel);
    check("en", int'(en), (active && ph >= BLANK) ? 1 : 0);
    check("digit", int'(digit), m_digit);
    check("frame_done", int'(frame_done), int'(m_fd));
    check("busy", int'(busy), int'(active));
    if (exp_period > 0 && frame_done) begin
      npulse++;
      if (npulse >= 3) check("frame_period", cyc - last_fd, exp_period);
      last_fd = cyc;
    end
  endtask

  task automatic run_phase(input int n, input int period);
    exp_period = period;
    npulse = 0;
    last_fd = 0;
    for (int i = 0; i < n; i++) step();
    if (period > 0) check("frame_pulses_seen", (npulse >= 3) ? 1 : 0, 1);
    exp_period = 0;
  endtask

  initial begin
    rst = 1'b1; run = 1'b1; mask = 4'hF; data = 16'hDCBA;
    exp_period = 0;
    active = 0; ph = 0; m_sel = 0; m_digit = 0; m_fd = 0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) step();

    rst = 1'b0;
    run_phase(80, 24);
    mask = 4'b1010;
    run_phase(60, 12);
    mask = 4'b0100;
    run_phase(40, 6);

    // Drop run partway into a dwell, then restart and change mask mid-dwell.
    mask = 4'hF;
    run = 1'b0;
    for (int i = 0; i < 12; i++) step();
    run = 1'b1;
    for (int i = 0; i < 10; i++) step();
    run = 1'b0;
    for (int i = 0; i < 10; i++) step();
    check("idle_after_stop", int'(busy), 0);
    run = 1'b1;
    for (int i = 0; i < 9; i++) step();
    mask = 4'b0001;
    for (int i = 0; i < 12; i++) step();

    mask = 4'h0;
    run = 1'b0;
    for (int i = 0; i < 8; i++) step();
    run = 1'b1;
    for (int i = 0; i < 10; i++) step();
    check("mask0_idle", int'(busy), 0);

    // Reset mid-drive, then restart.
    mask = 4'hF;
    for (int i = 0; i < 5; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) step();

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(99) < 4) run = ~run;
      if ($urandom_range(99) < 3) mask = 4'($urandom);
      data = 16'($urandom);
      rst = ($urandom_range(199) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
